out_port_ctrl: RTL
==================

OUT_PORT_CTRL -- requirements
Module: out_port_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25000000, meaning clock cycles per LED blink half-period, legal range 2 or greater.
REQ-002 SHALL have port clock, input, 1, meaning the single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port req0, input, 1, meaning write request from requester 0 (CPU store path).
REQ-005 SHALL have port sel0, input, 2, meaning target field of the requester 0 write.
REQ-006 SHALL have port data0, input, 12, meaning write data from requester 0.
REQ-007 SHALL have port gnt0, output, 1, meaning one-cycle grant and write-commit pulse for requester 0.
REQ-008 SHALL have ports req1, sel1, data1 and gnt1, with the same directions, widths and meanings as REQ-004 to REQ-007, for requester 1 (debug/monitor).
REQ-009 SHALL have port io_out, output, 34, with this layout: [23:0] holds six hex nibbles, digit 0 in bits [3:0]; [33:24] holds led9..led0, led0 in bit 24.

Function
REQ-010 SHALL decode sel as follows:
- 0: hex_lo[11:0], nibbles 0-2
- 1: hex_hi[11:0], nibbles 3-5
- 2: led[9:0] from data[9:0]
- 3: blink_en[9:0] from data[9:0]
- For sel 2 and 3, data[11:10] is ignored.
REQ-011 SHALL sample req/sel/data at each rising edge; an accepted write updates its field at that same edge, and the matching gnt is high for exactly the following cycle.
REQ-012 SHALL treat a requester as ineligible at an edge where its own gnt is currently high; holding req high therefore produces at most one write every 2 cycles.
REQ-013 SHALL grant the single eligible requester when only one is eligible.
REQ-014 SHALL resolve simultaneous eligible requests round-robin:
- grant the requester not granted most recently;
- after reset, requester 0 wins first.
REQ-015 SHALL never assert gnt0 and gnt1 in the same cycle, and SHALL perform exactly one field write per grant.
REQ-016 SHALL drive io_out[23:0] as {hex_hi, hex_lo} directly from registers, visible the cycle after the commit edge.
REQ-017 SHALL drive io_out[24+i] = led[i] AND (NOT blink_en[i] OR phase) for each LED i.
REQ-018 SHALL behave as follows for the blink counter:
- counts 0 to BLINK_DIV-1;
- on the edge where it equals BLINK_DIV-1, it wraps to 0 and phase toggles;
- it free-runs and is unaffected by writes.
REQ-019 SHALL, when blink_en[i] is cleared, show a steady led[i] from the cycle after the commit.

Reset
REQ-020 SHALL, on any edge with reset high:
- clear hex_lo, hex_hi, led, blink_en, the counter and phase;
- clear gnt0 and gnt1;
- set the round-robin pointer to favour requester 0;
- discard any write in that cycle.
REQ-021 SHALL drive io_out all zeros in the cycle after a reset edge.
REQ-022 SHALL apply reset asserted mid-grant as follows: the already committed write is lost and no gnt is issued while reset is high.

Structure
REQ-023 SHALL take the following from shared package out_ports_pkg:
- sel encodings (SEL_HEX_LO=0, SEL_HEX_HI=1, SEL_LED=2, SEL_BLINK=3);
- IO_OUT_W=34, HEX_W=24, LED_W=10, LED_BASE=24.
REQ-024 SHALL place the counter and phase in one sub-module, blink_timer, with parameter BLINK_DIV and output phase; arbitration and the field registers stay in out_port_ctrl.
REQ-025 SHALL size the counter as the ceiling of log2(BLINK_DIV) bits.

Verification
REQ-026 SHALL test a single write: req0=1, sel0=0, data0=0x321 for one cycle -> gnt0 high the next cycle, io_out[11:0]=0x321, all other bits 0.
REQ-027 SHALL test a conflict: req0 and req1 held high with sel=2, data0=0x3FF, data1=0x001 -> grants alternate gnt0, gnt1, gnt0 on every other cycle, never both high; io_out[33:24] tracks the last committed value.
REQ-028 SHALL test blink with BLINK_DIV=4: led=0x3FF and blink_en=0x001 -> io_out[24] toggles every 4 cycles; io_out[33:25] stays all ones.
REQ-029 SHALL test blink disable: clearing blink_en while phase=0 -> io_out[24]=1 the cycle after the commit.
REQ-030 SHALL test reset mid-operation: reset pulsed during the gnt1 cycle after a hex_hi write of 0xABC -> gnt1=0, io_out=0, and the next simultaneous request grants requester 0 first.

Source files
------------

// File: rtl/out_ports_pkg.sv
// Shared field encodings and io_out layout for the output-port controller.
package out_ports_pkg;

    typedef enum logic [1:0] {
        SEL_HEX_LO = 2'd0,
        SEL_HEX_HI = 2'd1,
        SEL_LED    = 2'd2,
        SEL_BLINK  = 2'd3
    } sel_e;

    localparam int unsigned IO_OUT_W    = 34;
    localparam int unsigned HEX_W       = 24;
    localparam int unsigned LED_W       = 10;
    localparam int unsigned LED_BASE    = 24;
    localparam int unsigned DATA_W      = 12;
    localparam int unsigned HEX_FIELD_W = HEX_W / 2;

endpackage

// File: rtl/blink_timer.sv
// Free-running blink divider: phase toggles every BLINK_DIV clock cycles.
module blink_timer #(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    output logic phase
);

    localparam int unsigned      CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/out_port_ctrl.sv
// Two-requester output-port controller: round-robin write arbitration into hex/LED/blink
// field registers, driving a packed io_out word.
module out_port_ctrl
    import out_ports_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req0,
    input  logic [1:0]          sel0,
    input  logic [DATA_W-1:0]   data0,
    output logic                gnt0,
    input  logic                req1,
    input  logic [1:0]          sel1,
    input  logic [DATA_W-1:0]   data1,
    output logic                gnt1,
    output logic [IO_OUT_W-1:0] io_out
);

    logic                   gnt0_q, gnt1_q;
    logic                   prio1_q;
    logic [HEX_FIELD_W-1:0] hex_lo_q, hex_hi_q;
    logic [LED_W-1:0]       led_q, blink_q, led_vis;
    logic                   phase;

    logic              elig0, elig1, grant0, grant1, wen;
    logic [1:0]        wsel;
    logic [DATA_W-1:0] wdata;

    // A requester whose grant is showing this cycle sits out this edge.
    always_comb begin
        elig0  = req0 & ~gnt0_q;
        elig1  = req1 & ~gnt1_q;
        grant0 = elig0 & (~elig1 | ~prio1_q);
        grant1 = elig1 & (~elig0 | prio1_q);
        wen    = grant0 | grant1;
        wsel   = grant1 ? sel1 : sel0;
        wdata  = grant1 ? data1 : data0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            prio1_q  <= 1'b0;
            hex_lo_q <= '0;
            hex_hi_q <= '0;
            led_q    <= '0;
            blink_q  <= '0;
        end else begin
            gnt0_q <= grant0;
            gnt1_q <= grant1;
            if (wen) begin
                prio1_q <= grant0;
                unique case (sel_e'(wsel))
                    SEL_HEX_LO: hex_lo_q <= wdata;
                    SEL_HEX_HI: hex_hi_q <= wdata;
                    SEL_LED:    led_q    <= wdata[LED_W-1:0];
                    SEL_BLINK:  blink_q  <= wdata[LED_W-1:0];
                endcase
            end
        end
    end

    blink_timer #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink_timer (
        .clock(clock),
        .reset(reset),
        .phase(phase)
    );

    always_comb begin
        led_vis                     = led_q & (~blink_q | {LED_W{phase}});
        io_out                      = '0;
        io_out[HEX_W-1:0]           = {hex_hi_q, hex_lo_q};
        io_out[LED_BASE +: LED_W]   = led_vis;
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;

endmodule
